ram_sdp_be: RTL and testbench

- Parametrised simple-dual-port synchronous RAM: one write port with byte enables, one read port, running concurrently.
- Successor to the fixed 8x8 single-port RAM.
- Replaces the single-cycle clear of every location with a sequential clear engine that sweeps one address per cycle, so the block maps to block RAM.
- Adds a selectable read-during-write policy and a read-valid strobe; used as a general scratch/buffer memory.

---
 rtl/ram_sdp_be.sv | 124 ++++++++++++
 tb/tb_ram_sdp_be.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/ram_sdp_be.sv
// Simple-dual-port RAM with byte-enable writes, registered reads and a sequential clear engine.
// The clear engine sweeps one word per cycle so the array can map onto block RAM.
//
// state    | meaning
// ST_CLEAR | sweeping zeros into mem[clr_adr]; busy=1, all requests ignored
// ST_READY | normal read/write service
module ram_sdp_be #(
  parameter int DATA_W    = 8,
  parameter int ADR_W     = 3,
  parameter int DEPTH     = 8,
  parameter int RD_BYPASS = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  wr_en,
  input  logic [ADR_W-1:0]      wr_adr,
  input  logic [DATA_W-1:0]     wr_data,
  input  logic [DATA_W/8-1:0]   wr_be,
  input  logic                  rd_en,
  input  logic [ADR_W-1:0]      rd_adr,
  output logic [DATA_W-1:0]     rd_data,
  output logic                  rd_valid,
  output logic                  busy
);

  localparam int NB = DATA_W / 8;
  localparam logic [ADR_W:0]   DEPTH_W  = (ADR_W + 1)'(DEPTH);
  localparam logic [ADR_W-1:0] LAST_ADR = ADR_W'(DEPTH - 1);

  typedef enum logic {ST_CLEAR, ST_READY} state_t;

  state_t              state_q, state_d;
  logic [ADR_W-1:0]    clr_adr_q, clr_adr_d;
  logic [DATA_W-1:0]   rd_data_q, rd_data_d;
  logic                rd_valid_q, rd_valid_d;
  logic [DATA_W-1:0]   mem_q [DEPTH];

  logic                mem_we;
  logic [ADR_W-1:0]    mem_adr;
  logic [DATA_W-1:0]   mem_wdata;
  logic [NB-1:0]       mem_be;

  logic                wr_in_range;
  logic                rd_in_range;
  logic                collide;
  logic [DATA_W-1:0]   rd_old;
  logic [DATA_W-1:0]   rd_merged;

  always_comb begin
    wr_in_range = ({1'b0, wr_adr} < DEPTH_W);
    rd_in_range = ({1'b0, rd_adr} < DEPTH_W);
    collide     = wr_en && rd_en && wr_in_range && (wr_adr == rd_adr);
    rd_old      = rd_in_range ? mem_q[rd_adr] : '0;
    for (int b = 0; b < NB; b++) begin
      rd_merged[8*b +: 8] = wr_be[b] ? wr_data[8*b +: 8] : rd_old[8*b +: 8];
    end
  end

  always_comb begin
    state_d    = state_q;
    clr_adr_d  = clr_adr_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    mem_we     = 1'b0;
    mem_adr    = clr_adr_q;
    mem_wdata  = '0;
    mem_be     = '1;

    if (rst) begin
      state_d   = ST_CLEAR;
      clr_adr_d = '0;
      rd_data_d = '0;
    end else if (clr) begin
      // restart from address 0 whether idle or mid-sweep; rd_data is deliberately held
      state_d   = ST_CLEAR;
      clr_adr_d = '0;
    end else begin
      case (state_q)
        ST_CLEAR: begin
          mem_we    = 1'b1;
          clr_adr_d = clr_adr_q + 1'b1;
          if (clr_adr_q == LAST_ADR) begin
            state_d   = ST_READY;
            clr_adr_d = '0;
          end
        end
        default: begin
          if (wr_en && wr_in_range && (|wr_be)) begin
            mem_we    = 1'b1;
            mem_adr   = wr_adr;
            mem_wdata = wr_data;
            mem_be    = wr_be;
          end
          if (rd_en) begin
            rd_valid_d = 1'b1;
            rd_data_d  = (collide && (RD_BYPASS != 0)) ? rd_merged : rd_old;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    state_q    <= state_d;
    clr_adr_q  <= clr_adr_d;
    rd_data_q  <= rd_data_d;
    rd_valid_q <= rd_valid_d;
  end

  // array has no reset so it can be inferred as block RAM
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < NB; b++) begin
        if (mem_be[b]) mem_q[mem_adr][8*b +: 8] <= mem_wdata[8*b +: 8];
      end
    end
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign busy     = (state_q == ST_CLEAR);

endmodule

// File: tb/tb_ram_sdp_be.sv
// Scoreboard bench for ram_sdp_be: instance 0 is 32b/DEPTH 8/write-first,
// instance 1 is 32b/DEPTH 6/read-first.
module tb_ram_sdp_be;

  logic        clk;
  logic        rst;
  logic        clr     [2];
  logic        wr_en   [2];
  logic [2:0]  wr_adr  [2];
  logic [31:0] wr_data [2];
  logic [3:0]  wr_be   [2];
  logic        rd_en   [2];
  logic [2:0]  rd_adr  [2];
  logic [31:0] rd_data [2];
  logic        rd_valid[2];
  logic        busy    [2];

  logic [31:0] exp_q0[$];
  logic [31:0] exp_q1[$];

  int checks;
  int errors;

  ram_sdp_be #(.DATA_W(32), .ADR_W(3), .DEPTH(8), .RD_BYPASS(1)) u_a (
    .clk(clk), .rst(rst), .clr(clr[0]),
    .wr_en(wr_en[0]), .wr_adr(wr_adr[0]), .wr_data(wr_data[0]), .wr_be(wr_be[0]),
    .rd_en(rd_en[0]), .rd_adr(rd_adr[0]),
    .rd_data(rd_data[0]), .rd_valid(rd_valid[0]), .busy(busy[0])
  );

  ram_sdp_be #(.DATA_W(32), .ADR_W(3), .DEPTH(6), .RD_BYPASS(0)) u_b (
    .clk(clk), .rst(rst), .clr(clr[1]),
    .wr_en(wr_en[1]), .wr_adr(wr_adr[1]), .wr_data(wr_data[1]), .wr_be(wr_be[1]),
    .rd_en(rd_en[1]), .rd_adr(rd_adr[1]),
    .rd_data(rd_data[1]), .rd_valid(rd_valid[1]), .busy(busy[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic op(input int i, input bit we, input logic [2:0] wa, input logic [31:0] wd,
                    input logic [3:0] be, input bit re, input logic [2:0] ra,
                    input logic [31:0] exp);
    wr_en[i] = we; wr_adr[i] = wa; wr_data[i] = wd; wr_be[i] = be;
    rd_en[i] = re; rd_adr[i] = ra;
    if (re) begin
      if (i == 0) exp_q0.push_back(exp);
      else        exp_q1.push_back(exp);
    end
    tick();
    wr_en[i] = 1'b0;
    rd_en[i] = 1'b0;
  endtask

  task automatic wr(input int i, input logic [2:0] a, input logic [31:0] d, input logic [3:0] be);
    op(i, 1'b1, a, d, be, 1'b0, 3'd0, 32'h0);
  endtask

  task automatic rd(input int i, input logic [2:0] a, input logic [31:0] exp);
    op(i, 1'b0, 3'd0, 32'h0, 4'h0, 1'b1, a, exp);
  endtask

  // counts busy cycles from the current negedge; optionally issues reads while busy
  task automatic wait_sweep(input int ea, input int eb, input bit probe);
    int ca = 0;
    int cb = 0;
    for (int n = 0; n < 40; n++) begin
      if (busy[0] !== 1'b1 && busy[1] !== 1'b1) break;
      if (busy[0] === 1'b1) ca++;
      if (busy[1] === 1'b1) cb++;
      rd_en[0] = probe & busy[0]; rd_adr[0] = 3'd0;
      rd_en[1] = probe & busy[1]; rd_adr[1] = 3'd0;
      tick();
    end
    rd_en[0] = 1'b0;
    rd_en[1] = 1'b0;
    check("busy cycles inst0", ca, ea);
    check("busy cycles inst1", cb, eb);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      clr[i] = 1'b0; wr_en[i] = 1'b0; wr_adr[i] = '0; wr_data[i] = '0;
      wr_be[i] = '0; rd_en[i] = 1'b0; rd_adr[i] = '0;
    end

    // monitor lives in this block so the counters have a single writer
    fork
      forever begin
        @(negedge clk);
        if (rd_valid[0] === 1'b1) begin
          if (exp_q0.size() == 0) begin
            checks++; errors++;
            $display("FAIL rd_valid inst0: got unexpected strobe, expected none (rd_data %h)", rd_data[0]);
          end else check("rd_data inst0", rd_data[0], exp_q0.pop_front());
        end
        if (rd_valid[1] === 1'b1) begin
          if (exp_q1.size() == 0) begin
            checks++; errors++;
            $display("FAIL rd_valid inst1: got unexpected strobe, expected none (rd_data %h)", rd_data[1]);
          end else check("rd_data inst1", rd_data[1], exp_q1.pop_front());
        end
      end
    join_none

    @(negedge clk);
    repeat (3) tick();
    check("reset rd_data inst0", rd_data[0], 32'h0);
    check("reset rd_data inst1", rd_data[1], 32'h0);
    check("reset rd_valid inst0", {31'h0, rd_valid[0]}, 32'h0);
    check("reset rd_valid inst1", {31'h0, rd_valid[1]}, 32'h0);
    check("reset busy inst0", {31'h0, busy[0]}, 32'h1);
    check("reset busy inst1", {31'h0, busy[1]}, 32'h1);
    rst = 1'b0;
    wait_sweep(8, 6, 1'b1);

    // garbage preload, then a one-cycle reset must wipe it
    for (int a = 0; a < 8; a++) wr(0, 3'(a), 32'hDEAD_0000 | a, 4'hF);
    for (int a = 0; a < 6; a++) wr(1, 3'(a), 32'hBEEF_0000 | a, 4'hF);
    rd(0, 3'd3, 32'hDEAD_0003);
    rd(1, 3'd4, 32'hBEEF_0004);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    wait_sweep(8, 6, 1'b1);
    for (int a = 0; a < 8; a++) rd(0, 3'(a), 32'h0);
    for (int a = 0; a < 6; a++) rd(1, 3'(a), 32'h0);

    // byte enables
    wr(0, 3'd2, 32'hAABB_CCDD, 4'b1111);
    wr(0, 3'd2, 32'h1122_3344, 4'b0101);
    rd(0, 3'd2, 32'hAA22_CC44);
    tick();
    check("hold rd_data inst0", rd_data[0], 32'hAA22_CC44);
    check("idle rd_valid inst0", {31'h0, rd_valid[0]}, 32'h0);
    wr(0, 3'd4, 32'h0102_0304, 4'b0000);
    rd(0, 3'd4, 32'h0);

    // independent read and write at different addresses
    op(0, 1'b1, 3'd3, 32'hCAFE_BABE, 4'hF, 1'b1, 3'd2, 32'hAA22_CC44);
    rd(0, 3'd3, 32'hCAFE_BABE);

    // collisions: write-first on inst0, read-first on inst1
    wr(0, 3'd5, 32'h0000_FFFF, 4'hF);
    op(0, 1'b1, 3'd5, 32'h1234_5678, 4'b1100, 1'b1, 3'd5, 32'h1234_FFFF);
    rd(0, 3'd5, 32'h1234_FFFF);
    wr(1, 3'd5, 32'h0000_FFFF, 4'hF);
    op(1, 1'b1, 3'd5, 32'h1234_5678, 4'b1100, 1'b1, 3'd5, 32'h0000_FFFF);
    rd(1, 3'd5, 32'h1234_FFFF);

    // out of range on DEPTH=6
    op(1, 1'b1, 3'd7, 32'h0000_005A, 4'hF, 1'b1, 3'd7, 32'h0);
    op(1, 1'b1, 3'd6, 32'hA5A5_A5A5, 4'hF, 1'b1, 3'd6, 32'h0);
    rd(1, 3'd6, 32'h0);
    for (int a = 0; a < 5; a++) rd(1, 3'(a), 32'h0);
    rd(1, 3'd5, 32'h1234_FFFF);

    // last address of the full-depth instance
    wr(0, 3'd7, 32'h8765_4321, 4'hF);
    rd(0, 3'd7, 32'h8765_4321);

    // clr with a concurrent write and read: both discarded, rd_data held
    clr[0] = 1'b1;
    wr_en[0] = 1'b1; wr_adr[0] = 3'd1; wr_data[0] = 32'h7777_7777; wr_be[0] = 4'hF;
    rd_en[0] = 1'b1; rd_adr[0] = 3'd7;
    tick();
    clr[0] = 1'b0; wr_en[0] = 1'b0; rd_en[0] = 1'b0;
    check("clr hold rd_data inst0", rd_data[0], 32'h8765_4321);
    check("clr busy inst0", {31'h0, busy[0]}, 32'h1);
    wait_sweep(8, 0, 1'b1);
    rd(0, 3'd1, 32'h0);
    rd(0, 3'd3, 32'h0);
    rd(0, 3'd7, 32'h0);
    rd(1, 3'd5, 32'h1234_FFFF);

    // clr during a sweep restarts it
    clr[1] = 1'b1; tick(); clr[1] = 1'b0;
    tick(); tick();
    clr[1] = 1'b1; tick(); clr[1] = 1'b0;
    wait_sweep(0, 6, 1'b1);
    rd(1, 3'd5, 32'h0);

    // rst at sweep cycle 3 restarts a full sweep
    wr(0, 3'd6, 32'h0000_0066, 4'hF);
    wr(1, 3'd2, 32'h2222_2222, 4'hF);
    clr[0] = 1'b1; tick(); clr[0] = 1'b0;
    tick(); tick(); tick();
    rst = 1'b1; tick(); rst = 1'b0;
    wait_sweep(8, 6, 1'b1);
    rd(0, 3'd6, 32'h0);
    rd(1, 3'd2, 32'h0);

    tick(); tick();
    check("pending reads inst0", exp_q0.size(), 32'h0);
    check("pending reads inst1", exp_q1.size(), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
